// File: rtl/mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Memory-side responder for the MOV/MOC handshake. Serves byte,
//             halfword and word reads/writes to a byte-addressed, big-endian
//             store of DEPTH bytes, with a fixed number of wait states
//             between request accept and completion. Misaligned or illegal
//             requests complete normally but raise MemErr and have no effect
//             on memory or DataOut.
//  Ports    : clock    - system clock, rising edge
//             reset    - asynchronous, active-low reset
//             MOV      - memory operation valid (initiator)
//             MemRead  - read qualifier
//             MemWrite - write qualifier
//             Size     - 00 byte, 01 halfword, 10 word, 11 illegal
//             SignExt  - 1: sign-extend narrow reads, 0: zero-extend
//             Address  - byte address (from MAR)
//             DataIn   - write data (from MDR)
//             DataOut  - read data, held until the next successful read
//             MOC      - memory operation complete
//             MemErr   - error status of the completed operation
//  Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int    ADDR_WIDTH  = 9,
  parameter int    DEPTH       = 512,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  MOV,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            Size,
  input  logic                  SignExt,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  output logic                  MOC,
  output logic                  MemErr
);

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_WORD = 2'b10;
  localparam logic [3:0] c_WAIT_CNT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;

  // Request captured at accept; the access uses only these copies.
  logic                  r_rd;
  logic                  r_wr;
  logic [1:0]            r_size;
  logic                  r_sext;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_din;

  logic [7:0]            r_mem [0:DEPTH-1];

  // Byte lanes of the access, wrapping modulo the store size.
  logic [ADDR_WIDTH-1:0] w_a0;
  logic [ADDR_WIDTH-1:0] w_a1;
  logic [ADDR_WIDTH-1:0] w_a2;
  logic [ADDR_WIDTH-1:0] w_a3;
  logic [7:0]            w_b0;
  logic [7:0]            w_b1;
  logic [7:0]            w_b2;
  logic [7:0]            w_b3;

  assign w_a0 = r_addr;
  assign w_a1 = r_addr + ADDR_WIDTH'(1);
  assign w_a2 = r_addr + ADDR_WIDTH'(2);
  assign w_a3 = r_addr + ADDR_WIDTH'(3);

  assign w_b0 = r_mem[w_a0];
  assign w_b1 = r_mem[w_a1];
  assign w_b2 = r_mem[w_a2];
  assign w_b3 = r_mem[w_a3];

  // Exactly one of read/write must be requested, size must be legal and
  // multi-byte accesses must be naturally aligned.
  logic w_err;
  assign w_err = (r_rd == r_wr)
              || (r_size == 2'b11)
              || ((r_size == c_SIZE_HALF) && r_addr[0])
              || ((r_size == c_SIZE_WORD) && (r_addr[1:0] != 2'b00));

  logic w_complete;
  logic w_commit_wr;
  assign w_complete  = (r_state == S_BUSY) && (r_cnt == 4'd0);
  // Gated by the state register, so an asynchronous reset during BUSY
  // forces IDLE and the pending write can never be committed.
  assign w_commit_wr = w_complete && !w_err && r_wr;

  // Big-endian read formatting with optional sign extension.
  logic [31:0] w_rdata;
  always_comb begin
    w_rdata = 32'd0;
    case (r_size)
      c_SIZE_BYTE: w_rdata = {{24{r_sext & w_b0[7]}}, w_b0};
      c_SIZE_HALF: w_rdata = {{16{r_sext & w_b0[7]}}, w_b0, w_b1};
      default:     w_rdata = {w_b0, w_b1, w_b2, w_b3};
    endcase
  end

  // Storage is not reset; contents survive a reset.
  always_ff @(posedge clock) begin
    if (w_commit_wr) begin
      case (r_size)
        c_SIZE_BYTE: begin
          r_mem[w_a0] <= r_din[7:0];
        end
        c_SIZE_HALF: begin
          r_mem[w_a0] <= r_din[15:8];
          r_mem[w_a1] <= r_din[7:0];
        end
        c_SIZE_WORD: begin
          r_mem[w_a0] <= r_din[31:24];
          r_mem[w_a1] <= r_din[23:16];
          r_mem[w_a2] <= r_din[15:8];
          r_mem[w_a3] <= r_din[7:0];
        end
        default: ;
      endcase
    end
  end

  // Handshake state machine with registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_size  <= 2'b00;
      r_sext  <= 1'b0;
      r_addr  <= '0;
      r_din   <= 32'd0;
      MOC     <= 1'b0;
      MemErr  <= 1'b0;
      DataOut <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (MOV) begin
            r_rd    <= MemRead;
            r_wr    <= MemWrite;
            r_size  <= Size;
            r_sext  <= SignExt;
            r_addr  <= Address;
            r_din   <= DataIn;
            r_cnt   <= c_WAIT_CNT;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            MOC     <= 1'b1;
            r_state <= S_DONE;
            if (w_err) begin
              MemErr <= 1'b1;
            end else begin
              MemErr <= 1'b0;
              // A legal request with r_rd set is a pure read.
              if (r_rd) begin
                DataOut <= w_rdata;
              end
            end
          end
        end
        S_DONE: begin
          // Completion is held until the initiator withdraws MOV.
          if (!MOV) begin
            MOC     <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Self-checking bench for mem_responder: directed vector table,
//             hand-written reset/hold sequences and randomized transactions
//             checked against a byte-array reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  localparam int WAIT = 2;

  logic        clock    = 1'b0;
  logic        reset    = 1'b0;
  logic        MOV      = 1'b0;
  logic        MemRead  = 1'b0;
  logic        MemWrite = 1'b0;
  logic [1:0]  Size     = 2'b00;
  logic        SignExt  = 1'b0;
  logic [8:0]  Address  = 9'd0;
  logic [31:0] DataIn   = 32'd0;
  logic [31:0] DataOut;
  logic        MOC;
  logic        MemErr;

  mem_responder #(
    .ADDR_WIDTH  (9),
    .DEPTH       (512),
    .WAIT_CYCLES (WAIT),
    .INIT_FILE   ("")
  ) u_dut (
    .clock    (clock),
    .reset    (reset),
    .MOV      (MOV),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Size     (Size),
    .SignExt  (SignExt),
    .Address  (Address),
    .DataIn   (DataIn),
    .DataOut  (DataOut),
    .MOC      (MOC),
    .MemErr   (MemErr)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state
  logic [7:0]  mem_m [512];
  logic [31:0] exp_dout = 32'd0;
  logic        exp_err  = 1'b0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        sx;
    logic [8:0]  a;
    logic [31:0] d;
    int          hold;
    logic [31:0] edout;
    logic        eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic sx, input logic [8:0] a, input logic [31:0] d,
                              input int hold, input logic [31:0] edout, input logic eerr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.sx = sx; v.a = a; v.d = d;
    v.hold = hold; v.edout = edout; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: bytes in an array, values built arithmetically.
  function automatic void model(input logic rd, input logic wr, input logic [1:0] sz,
                                input logic sx, input logic [8:0] a, input logic [31:0] d);
    int     n;
    longint v;
    if (rd == wr || sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)) begin
      exp_err = 1'b1;
      return;
    end
    exp_err = 1'b0;
    n = 1 << sz;
    if (wr) begin
      for (int i = 0; i < n; i++)
        mem_m[(int'(a) + i) % 512] = 8'(d >> (8 * (n - 1 - i)));
    end else begin
      v = 0;
      for (int i = 0; i < n; i++)
        v = v * 256 + longint'(mem_m[(int'(a) + i) % 512]);
      if (sx && n < 4 && v >= (longint'(1) << (8 * n - 1)))
        v = v - (longint'(1) << (8 * n));
      exp_dout = 32'(v);
    end
  endfunction

  // One handshake. hold < 0: drop MOV right after accept (during BUSY);
  // hold >= 0: keep MOV high for 'hold' cycles after MOC rises.
  task automatic do_txn(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                        input logic [8:0] a, input logic [31:0] d, input int hold,
                        output logic [31:0] dout, output logic err);
    int k;
    int bad;
    logic seen;
    @(negedge clock);
    MOV = 1'b1; MemRead = rd; MemWrite = wr; Size = sz; SignExt = sx;
    Address = a; DataIn = d;
    @(posedge clock);
    #1;
    // Post-accept input changes must not matter.
    MemRead  = 1'($urandom);
    MemWrite = 1'($urandom);
    Size     = 2'($urandom);
    SignExt  = 1'($urandom);
    Address  = 9'($urandom);
    DataIn   = $urandom;
    if (hold < 0) MOV = 1'b0;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      @(posedge clock);
      #1;
      k++;
      seen = MOC;
    end
    if (!seen) chk("moc_timeout", 32'd0, 32'd1);
    else       chk("moc_latency", 32'(k), 32'(WAIT + 1));
    dout = DataOut;
    err  = MemErr;
    if (hold >= 0) begin
      bad = 0;
      repeat (hold) begin
        @(posedge clock);
        #1;
        if (MOC !== 1'b1 || DataOut !== dout || MemErr !== err) bad++;
      end
      if (hold > 0) chk("moc_hold", 32'(bad), 32'd0);
      MOV = 1'b0;
    end
    @(posedge clock);
    #1;
    chk("moc_clear", {31'd0, MOC}, 32'd0);
  endtask

  task automatic run_model(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                           input logic [8:0] a, input logic [31:0] d, input int hold,
                           input string tag);
    logic [31:0] dout;
    logic        err;
    model(rd, wr, sz, sx, a, d);
    do_txn(rd, wr, sz, sx, a, d, hold, dout, err);
    chk({tag, "_dout"}, dout, exp_dout);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dout;
    logic        err;
    logic [31:0] oldw;
    int          k;
    logic        seen;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clock);
    chk("rst_moc",  {31'd0, MOC},    32'd0);
    chk("rst_dout", DataOut,         32'd0);
    chk("rst_err",  {31'd0, MemErr}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // ---------------- known contents everywhere ----------------
    for (int w = 0; w < 128; w++)
      run_model(1'b0, 1'b1, 2'd2, 1'b0, 9'(w * 4), $urandom, 0, "fill");

    // ---------------- directed table ----------------
    tbl.push_back(mk(0,1,2'd2,0,9'd0,  32'h2401002C, 0, 32'h00000000,0));
    tbl.push_back(mk(1,0,2'd2,0,9'd0,  32'h0,        0, 32'h2401002C,0));
    tbl.push_back(mk(0,1,2'd2,0,9'd8,  32'hDEADBEEF,-1, 32'h2401002C,0));
    tbl.push_back(mk(1,0,2'd1,1,9'd10, 32'h0,        0, 32'hFFFFBEEF,0));
    tbl.push_back(mk(1,0,2'd1,0,9'd10, 32'h0,        1, 32'h0000BEEF,0));
    tbl.push_back(mk(0,1,2'd2,0,9'd4,  32'h11223344, 0, 32'h0000BEEF,0));
    tbl.push_back(mk(0,1,2'd0,0,9'd5,  32'h12345680, 0, 32'h0000BEEF,0));
    tbl.push_back(mk(1,0,2'd0,1,9'd5,  32'h0,       -1, 32'hFFFFFF80,0));
    tbl.push_back(mk(1,0,2'd2,0,9'd4,  32'h0,        0, 32'h11803344,0));
    tbl.push_back(mk(0,1,2'd2,0,9'd6,  32'hAAAAAAAA, 0, 32'h11803344,1));
    tbl.push_back(mk(1,1,2'd1,0,9'd8,  32'h55555555, 0, 32'h11803344,1));
    tbl.push_back(mk(1,0,2'd3,0,9'd0,  32'h0,        0, 32'h11803344,1));
    tbl.push_back(mk(0,0,2'd2,0,9'd0,  32'h0,       -1, 32'h11803344,1));
    tbl.push_back(mk(1,0,2'd1,0,9'd9,  32'h0,        0, 32'h11803344,1));
    tbl.push_back(mk(1,0,2'd2,0,9'd4,  32'h0,        0, 32'h11803344,0));
    tbl.push_back(mk(1,0,2'd2,0,9'd8,  32'h0,        0, 32'hDEADBEEF,0));
    tbl.push_back(mk(0,1,2'd2,0,9'd508,32'hCAFEF00D, 5, 32'hDEADBEEF,0));
    tbl.push_back(mk(1,0,2'd0,0,9'd511,32'h0,        0, 32'h0000000D,0));
    tbl.push_back(mk(1,0,2'd1,1,9'd510,32'h0,        0, 32'hFFFFF00D,0));
    tbl.push_back(mk(1,0,2'd2,1,9'd508,32'h0,        0, 32'hCAFEF00D,0));
    tbl.push_back(mk(1,0,2'd0,0,9'd5,  32'h0,        0, 32'h00000080,0));
    tbl.push_back(mk(0,1,2'd1,0,9'd2,  32'hABCD8001, 0, 32'h00000080,0));
    tbl.push_back(mk(1,0,2'd2,0,9'd0,  32'h0,        0, 32'h24018001,0));

    for (int i = 0; i < tbl.size(); i++) begin
      model(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].sx, tbl[i].a, tbl[i].d);
      do_txn(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].sx, tbl[i].a, tbl[i].d,
             tbl[i].hold, dout, err);
      chk($sformatf("vec%0d_dout", i), dout, tbl[i].edout);
      chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, tbl[i].eerr});
    end

    // ---------------- reset during BUSY aborts a write ----------------
    oldw = {mem_m[12], mem_m[13], mem_m[14], mem_m[15]};
    @(negedge clock);
    MOV = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Size = 2'd2; SignExt = 1'b0;
    Address = 9'd12; DataIn = ~oldw;
    @(posedge clock);                 // accept
    #2 MOV = 1'b0;
    @(posedge clock);
    @(posedge clock);                 // two cycles in, commit still pending
    #2 reset = 1'b0;
    #1;
    chk("abort_moc",  {31'd0, MOC},    32'd0);
    chk("abort_dout", DataOut,         32'd0);
    chk("abort_err",  {31'd0, MemErr}, 32'd0);
    exp_dout = 32'd0;
    exp_err  = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    run_model(1'b1, 1'b0, 2'd2, 1'b0, 9'd12, 32'd0, 0, "abort_read");
    chk("abort_old", exp_dout, oldw);

    // ---------------- asynchronous reset while DONE ----------------
    model(1'b1, 1'b0, 2'd2, 1'b0, 9'd0, 32'd0);
    @(negedge clock);
    MOV = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Size = 2'd2; Address = 9'd0;
    @(posedge clock);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      @(posedge clock);
      #1;
      k++;
      seen = MOC;
    end
    chk("done_rst_lat", 32'(k), 32'(WAIT + 1));
    chk("done_rst_data", DataOut, exp_dout);
    #2 reset = 1'b0;
    #1;
    chk("done_rst_moc",  {31'd0, MOC}, 32'd0);
    chk("done_rst_dout", DataOut,      32'd0);
    exp_dout = 32'd0;
    exp_err  = 1'b0;
    MOV = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // ---------------- randomized against the model ----------------
    for (int i = 0; i < 200; i++) begin
      logic       rd, wr, sx;
      logic [1:0] sz;
      logic [8:0] a;
      int         r;
      r = int'($urandom_range(0, 15));
      if (r == 0)      begin rd = 1'b1; wr = 1'b1; end
      else if (r == 1) begin rd = 1'b0; wr = 1'b0; end
      else begin rd = 1'($urandom); wr = ~rd; end
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = 9'($urandom);
      if ($urandom_range(0, 7) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      sx = 1'($urandom);
      run_model(rd, wr, sz, sx, a, $urandom, int'($urandom_range(0, 3)) - 1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
